// File: rtl/pma_pkg.sv
// Shared types for the PMA region table: attribute triple and per-entry rule record.
package pma_pkg;

    localparam int unsigned PMA_ATTR_W = 3;
    localparam int unsigned PMA_MAX_AW = 64;

    typedef struct packed {
        logic cached;
        logic exec;
        logic nonidem;
    } pma_attr_t;

    // Address fields are sized for the widest supported AddrWidth; a table
    // built for a narrower space uses the low AddrWidth bits only.
    typedef struct packed {
        logic [PMA_MAX_AW-1:0] base;
        logic [PMA_MAX_AW-1:0] len;
        pma_attr_t             attr;
        logic                  lock;
    } pma_rule_t;

endpackage

// File: rtl/pma_rule_match.sv
// Single-entry region comparator: enabled when len != 0, matches base <= addr < base + len.
module pma_rule_match
    import pma_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] len_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 match_o
);

    // One extra bit lets a region ending exactly at the top of the space
    // cover the all-ones address instead of wrapping to zero.
    logic [AddrWidth:0] limit;

    assign limit   = {1'b0, base_i} + {1'b0, len_i};
    assign match_o = (len_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < limit);

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA table with a one-deep registered lookup port.
// Define PMA_REGION_LOCK_EN to build per-entry lock bits that reject rewrites.
module pma_region_table
    import pma_pkg::*;
#(
    parameter int unsigned                     NrRules   = 4,
    parameter int unsigned                     AddrWidth = 64,
    parameter logic [NrRules*AddrWidth-1:0]    RstBase   = '0,
    parameter logic [NrRules*AddrWidth-1:0]    RstLen    = '0,
    parameter logic [NrRules*PMA_ATTR_W-1:0]   RstAttr   = '0,
    localparam int unsigned                    IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AddrWidth-1:0]  req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [IdxW-1:0]       rsp_idx_o,
    output logic [PMA_ATTR_W-1:0] rsp_attr_o,
    input  logic                  cfg_we_i,
    input  logic [IdxW-1:0]       cfg_idx_i,
    input  logic [AddrWidth-1:0]  cfg_base_i,
    input  logic [AddrWidth-1:0]  cfg_len_i,
    input  logic [PMA_ATTR_W-1:0] cfg_attr_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_err_o,
    output logic [15:0]           miss_cnt_o
);

    pma_rule_t       rules_q [NrRules];
    pma_rule_t       rules_d [NrRules];
    pma_rule_t       rst_rules [NrRules];
    logic [NrRules-1:0] match;

    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_hit_q, rsp_hit_d;
    logic [IdxW-1:0] rsp_idx_q, rsp_idx_d;
    pma_attr_t       rsp_attr_q, rsp_attr_d;
    logic [15:0]     miss_cnt_q, miss_cnt_d;
    logic            cfg_err_q, cfg_err_d;

    logic            sel_hit;
    logic [IdxW-1:0] sel_idx;
    pma_attr_t       sel_attr;
    logic            req_accept;
    logic            idx_valid;
    logic            idx_locked;
    logic            wr_en;

    for (genvar g = 0; g < NrRules; g++) begin : g_match
        pma_rule_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .base_i  (rules_q[g].base[AddrWidth-1:0]),
            .len_i   (rules_q[g].len[AddrWidth-1:0]),
            .addr_i  (req_addr_i),
            .match_o (match[g])
        );
    end

    // NOTE: every variable written in a combinational block gets a default
    // before any conditional assignment, otherwise a latch is inferred.
    always_comb begin
        for (int i = 0; i < NrRules; i++) begin
            rst_rules[i]                      = '0;
            rst_rules[i].base[AddrWidth-1:0]  = RstBase[i*AddrWidth +: AddrWidth];
            rst_rules[i].len[AddrWidth-1:0]   = RstLen[i*AddrWidth +: AddrWidth];
            rst_rules[i].attr                 = pma_attr_t'(RstAttr[i*PMA_ATTR_W +: PMA_ATTR_W]);
        end
    end

    // Walking from the top index down leaves the lowest matching entry selected.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = '0;
        sel_attr = '0;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_hit  = 1'b1;
                sel_idx  = IdxW'(i);
                sel_attr = rules_q[i].attr;
            end
        end
    end

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign req_accept  = req_valid_i && req_ready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_attr_d  = rsp_attr_q;
        miss_cnt_d  = miss_cnt_q;
        if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = sel_hit;
            rsp_idx_d   = sel_idx;
            rsp_attr_d  = sel_attr;
            if (!sel_hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        idx_valid  = 1'b0;
        idx_locked = 1'b0;
        for (int i = 0; i < NrRules; i++) begin
            if (cfg_idx_i == IdxW'(i)) begin
                idx_valid = 1'b1;
`ifdef PMA_REGION_LOCK_EN
                idx_locked = rules_q[i].lock;
`endif
            end
        end
        wr_en     = cfg_we_i && idx_valid && !idx_locked;
        cfg_err_d = cfg_we_i && !wr_en;

        rules_d = rules_q;
        for (int i = 0; i < NrRules; i++) begin
            if (wr_en && (cfg_idx_i == IdxW'(i))) begin
                rules_d[i].base                  = '0;
                rules_d[i].base[AddrWidth-1:0]   = cfg_base_i;
                rules_d[i].len                   = '0;
                rules_d[i].len[AddrWidth-1:0]    = cfg_len_i;
                rules_d[i].attr                  = pma_attr_t'(cfg_attr_i);
`ifdef PMA_REGION_LOCK_EN
                rules_d[i].lock                  = cfg_lock_i;
`else
                rules_d[i].lock                  = 1'b0;
`endif
            end
        end
    end

`ifndef PMA_REGION_LOCK_EN
    // Without lock support the lock field is held at zero and never read.
    logic unused_lock;
    always_comb begin
        unused_lock = cfg_lock_i;
        for (int i = 0; i < NrRules; i++) begin
            unused_lock = unused_lock ^ rules_q[i].lock;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the table is a small register file holding configuration, so it
    // is reset like any other flop rather than left uninitialised like a RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rules_q     <= rst_rules;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_attr_q  <= '0;
            miss_cnt_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            rules_q     <= rules_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_attr_q  <= rsp_attr_d;
            miss_cnt_q  <= miss_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_attr_o  = rsp_attr_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table; lock expectations follow PMA_REGION_LOCK_EN.
module tb_pma_region_table;

    localparam logic [255:0] RST_BASE = 256'h8000_0000;
    localparam logic [255:0] RST_LEN  = 256'h4000_0000;
    localparam logic [11:0]  RST_ATTR = 12'b110;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_addr_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic        rsp_hit_o;
    logic [1:0]  rsp_idx_o;
    logic [2:0]  rsp_attr_o;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_idx_i = '0;
    logic [63:0] cfg_base_i = '0;
    logic [63:0] cfg_len_i = '0;
    logic [2:0]  cfg_attr_i = '0;
    logic        cfg_lock_i = 1'b0;
    logic        cfg_err_o;
    logic [15:0] miss_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_miss = '0;

    pma_region_table #(
        .NrRules   (4),
        .AddrWidth (64),
        .RstBase   (RST_BASE),
        .RstLen    (RST_LEN),
        .RstAttr   (RST_ATTR)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_hit_o   (rsp_hit_o),
        .rsp_idx_o   (rsp_idx_o),
        .rsp_attr_o  (rsp_attr_o),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_base_i  (cfg_base_i),
        .cfg_len_i   (cfg_len_i),
        .cfg_attr_i  (cfg_attr_i),
        .cfg_lock_i  (cfg_lock_i),
        .cfg_err_o   (cfg_err_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [63:0] base,
                             input logic [63:0] len, input logic [2:0] attr,
                             input logic lock);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = idx;
        cfg_base_i = base;
        cfg_len_i  = len;
        cfg_attr_i = attr;
        cfg_lock_i = lock;
        step();
        cfg_we_i   = 1'b0;
        cfg_lock_i = 1'b0;
    endtask

    // Issues one request with the consumer ready; response is visible on return.
    task automatic lookup(input logic [63:0] addr);
        int guard = 0;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        #1;
        while (req_ready_o !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 10) begin
            n_fail++;
            $display("FAIL lookup_ready_timeout: req_ready_o got %b required 1", req_ready_o);
        end
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o, cfg_err_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: {v,h,idx,attr,err} got %b required 00000000",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o, cfg_err_o});
        end
        n_checks++;
        if (miss_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_miss_cnt: got %0d required 0", miss_cnt_o);
        end
        rst_ni = 1'b1;
        step();
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", req_ready_o);
        end
        exp_miss = '0;
    endtask

    task automatic test_reset_table();
        lookup(64'hBFFF_FFFF);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_00_110) begin
            n_fail++;
            $display("FAIL rst_tbl_last_byte: {v,h,idx,attr} got %b required 1100110",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        lookup(64'hC000_0000);
        exp_miss++;
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_0_00_000) begin
            n_fail++;
            $display("FAIL rst_tbl_past_end: {v,h,idx,attr} got %b required 1000000",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        n_checks++;
        if (miss_cnt_o !== exp_miss) begin
            n_fail++;
            $display("FAIL rst_tbl_miss_cnt: got %0d required %0d", miss_cnt_o, exp_miss);
        end
    endtask

    task automatic test_priority();
        cfg_write(2'd1, 64'h1_0000, 64'h1_0000, 3'b001, 1'b0);
        cfg_write(2'd2, 64'h0, 64'h10_0000, 3'b100, 1'b0);
        lookup(64'h1_0800);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_01_001) begin
            n_fail++;
            $display("FAIL prio_overlap: {v,h,idx,attr} got %b required 1101001",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        lookup(64'h2_0000);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_10_100) begin
            n_fail++;
            $display("FAIL prio_region_end: {v,h,idx,attr} got %b required 1110100",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1_0800;
        step();
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_idx_o, rsp_attr_o} !== 7'b0_1_01_001) begin
            n_fail++;
            $display("FAIL b2b_first: {rdy,v,idx,attr} got %b required 0101001",
                     {req_ready_o, rsp_valid_o, rsp_idx_o, rsp_attr_o});
        end
        req_addr_i = 64'h2_0000;
        step();
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_idx_o, rsp_attr_o} !== 7'b0_1_01_001) begin
            n_fail++;
            $display("FAIL b2b_held: {rdy,v,idx,attr} got %b required 0101001",
                     {req_ready_o, rsp_valid_o, rsp_idx_o, rsp_attr_o});
        end
        rsp_ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_release: got %b required 1", req_ready_o);
        end
        step();
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_10_100) begin
            n_fail++;
            $display("FAIL b2b_second: {v,h,idx,attr} got %b required 1110100",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        req_addr_i = 64'h8000_0000;
        step();
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_00_110) begin
            n_fail++;
            $display("FAIL b2b_third: {v,h,idx,attr} got %b required 1100110",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        req_valid_i = 1'b0;
        step();
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: rsp_valid got %b required 0", rsp_valid_o);
        end
    endtask

    task automatic test_lock();
        logic       exp_err;
        logic [6:0] exp_old;
        logic [6:0] exp_new;
`ifdef PMA_REGION_LOCK_EN
        exp_err = 1'b1;
        exp_old = 7'b1_1_11_010;
        exp_new = 7'b1_0_00_000;
`else
        exp_err = 1'b0;
        exp_old = 7'b1_0_00_000;
        exp_new = 7'b1_1_11_001;
`endif
        cfg_write(2'd3, 64'h4000_0000, 64'h100, 3'b010, 1'b1);
        n_checks++;
        if (cfg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_first_err: got %b required 0", cfg_err_o);
        end
        cfg_write(2'd3, 64'h5000_0000, 64'h100, 3'b001, 1'b0);
        n_checks++;
        if (cfg_err_o !== exp_err) begin
            n_fail++;
            $display("FAIL lock_second_err: got %b required %b", cfg_err_o, exp_err);
        end
        step();
        n_checks++;
        if (cfg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_err_pulse: got %b required 0", cfg_err_o);
        end
        lookup(64'h4000_0080);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== exp_old) begin
            n_fail++;
            $display("FAIL lock_old_base: {v,h,idx,attr} got %b required %b",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o}, exp_old);
        end
        lookup(64'h5000_0080);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== exp_new) begin
            n_fail++;
            $display("FAIL lock_new_base: {v,h,idx,attr} got %b required %b",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o}, exp_new);
        end
        exp_miss++;
        n_checks++;
        if (miss_cnt_o !== exp_miss) begin
            n_fail++;
            $display("FAIL lock_miss_cnt: got %0d required %0d", miss_cnt_o, exp_miss);
        end
    endtask

    task automatic test_top_of_space();
        cfg_write(2'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b101, 1'b0);
        lookup(64'hFFFF_FFFF_FFFF_FFFF);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_00_101) begin
            n_fail++;
            $display("FAIL top_all_ones: {v,h,idx,attr} got %b required 1100101",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        lookup(64'hFFFF_FFFF_FFFF_EFFF);
        exp_miss++;
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_0_00_000) begin
            n_fail++;
            $display("FAIL top_below_base: {v,h,idx,attr} got %b required 1000000",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        n_checks++;
        if (miss_cnt_o !== exp_miss) begin
            n_fail++;
            $display("FAIL top_miss_cnt: got %0d required %0d", miss_cnt_o, exp_miss);
        end
    endtask

    task automatic test_same_cycle();
        rsp_ready_i = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_idx_i   = 2'd1;
        cfg_base_i  = 64'h1_0000;
        cfg_len_i   = 64'h1_0000;
        cfg_attr_i  = 3'b011;
        cfg_lock_i  = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1_0800;
        step();
        cfg_we_i    = 1'b0;
        req_valid_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o, cfg_err_o} !== 8'b1_1_01_001_0) begin
            n_fail++;
            $display("FAIL same_cycle_old: {v,h,idx,attr,err} got %b required 11010010",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o, cfg_err_o});
        end
        lookup(64'h1_0800);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_01_011) begin
            n_fail++;
            $display("FAIL same_cycle_new: {v,h,idx,attr} got %b required 1101011",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
    endtask

    task automatic test_reset_stalled();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1_0800;
        step();
        req_valid_i = 1'b0;
        step();
        n_checks++;
        if ({rsp_valid_o, rsp_idx_o, rsp_attr_o} !== 6'b1_01_011) begin
            n_fail++;
            $display("FAIL rst_stall_pending: {v,idx,attr} got %b required 101011",
                     {rsp_valid_o, rsp_idx_o, rsp_attr_o});
        end
        rst_ni = 1'b0;
        step();
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o, cfg_err_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL rst_stall_discard: {v,h,idx,attr,err} got %b required 00000000",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o, cfg_err_o});
        end
        n_checks++;
        if (miss_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_stall_miss_clear: got %0d required 0", miss_cnt_o);
        end
        step();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        exp_miss    = '0;
        step();
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stall_ready: got %b required 1", req_ready_o);
        end
        lookup(64'hBFFF_FFFF);
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_1_00_110) begin
            n_fail++;
            $display("FAIL rst_stall_entry0: {v,h,idx,attr} got %b required 1100110",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        lookup(64'h1_0800);
        exp_miss++;
        n_checks++;
        if ({rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o} !== 7'b1_0_00_000) begin
            n_fail++;
            $display("FAIL rst_stall_entry1_cleared: {v,h,idx,attr} got %b required 1000000",
                     {rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_attr_o});
        end
        n_checks++;
        if (miss_cnt_o !== exp_miss) begin
            n_fail++;
            $display("FAIL rst_stall_miss_cnt: got %0d required %0d", miss_cnt_o, exp_miss);
        end
        cfg_write(2'd3, 64'h200, 64'h100, 3'b001, 1'b0);
        n_checks++;
        if (cfg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stall_unlocked: cfg_err got %b required 0", cfg_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_reset_table();
        test_priority();
        test_back_to_back();
        test_lock();
        test_top_of_space();
        test_same_cycle();
        test_reset_stalled();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
